// File: rtl/johnson_arb_pkg.sv
// -----------------------------------------------------------------------------
// johnson_arb_pkg
//   Shared types and helpers for the Johnson timer arbiter.
//   - arb_state_e    : arbiter FSM states (IDLE, RUN, DONE)
//   - DEF_* widths   : default parameter values for the arbiter
//   - next_johnson() : one Johnson step of a register up to MAX_CNT_WIDTH bits
// -----------------------------------------------------------------------------
package johnson_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_CNT_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH = 8;

  // Widest Johnson register the helper supports.
  localparam int unsigned MAX_CNT_WIDTH = 32;
  localparam int unsigned MAX_IDX_W     = $clog2(MAX_CNT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Shift left and feed back the inverted MSB of the 'width'-bit register.
  // Bits above 'width' are don't-care; the caller truncates the result.
  function automatic logic [MAX_CNT_WIDTH-1:0] next_johnson(
    input logic [MAX_CNT_WIDTH-1:0] value,
    input int unsigned              width
  );
    next_johnson = {value[MAX_CNT_WIDTH-2:0], ~value[MAX_IDX_W'(width - 1)]};
  endfunction

endpackage

// File: rtl/johnson_step_reg.sv
// -----------------------------------------------------------------------------
// johnson_step_reg
//   Johnson register with load-to-1, step and hold controls.
//   Ports:
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous active-low reset (register -> 1)
//     load_i  in   reload the register to 1 (wins over step_i)
//     step_i  in   advance one Johnson step
//     j_o     out  current register value
// -----------------------------------------------------------------------------
module johnson_step_reg
  import johnson_arb_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic [CNT_WIDTH-1:0] j_o
);

  logic [CNT_WIDTH-1:0] j_q;
  logic [CNT_WIDTH-1:0] j_d;

  always_comb begin
    j_d = j_q;
    if (load_i) begin
      j_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (step_i) begin
      j_d = CNT_WIDTH'(next_johnson(MAX_CNT_WIDTH'(j_q), CNT_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      j_q <= j_d;
    end
  end

  assign j_o = j_q;

endmodule

// File: rtl/johnson_timer_arbiter.sv
// -----------------------------------------------------------------------------
// johnson_timer_arbiter
//   Shares one Johnson-sequence timer between NUM_REQ requesters. A winner is
//   picked in IDLE, the timer is reloaded to 1 and stepped once per cycle for
//   the requested length, then a one-cycle Done pulse goes to the owner.
//   Ports:
//     Clk_In             in   clock, rising edge
//     Reset_In           in   asynchronous active-low reset
//     Enable_In          in   1 = operate, 0 = freeze all state
//     Req_In             in   level request per requester
//     Req_Len_In         in   step count per requester, LEN_WIDTH bits each
//     Grant_Out          out  one-hot timer owner, zero when idle
//     Busy_Out           out  timer owned (RUN or DONE)
//     Done_Out           out  one-cycle completion pulse to the owner
//     Johnson_State_Out  out  current Johnson register value
//     Steps_Left_Out     out  remaining steps of the current run
//   Build option:
//     JOHNSON_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins), no
//     round-robin pointer. Undefined: round-robin arbitration.
// -----------------------------------------------------------------------------
module johnson_timer_arbiter
  import johnson_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                         Clk_In,
  input  logic                         Reset_In,
  input  logic                         Enable_In,
  input  logic [NUM_REQ-1:0]           Req_In,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] Req_Len_In,
  output logic [NUM_REQ-1:0]           Grant_Out,
  output logic                         Busy_Out,
  output logic [NUM_REQ-1:0]           Done_Out,
  output logic [CNT_WIDTH-1:0]         Johnson_State_Out,
  output logic [LEN_WIDTH-1:0]         Steps_Left_Out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [LEN_WIDTH-1:0] steps_q, steps_d;
  logic                 j_load, j_step;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  int unsigned          search_base;
  logic [LEN_WIDTH-1:0] req_len [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign req_len[gi] = Req_Len_In[gi*LEN_WIDTH +: LEN_WIDTH];
  end

`ifdef JOHNSON_ARB_FIXED_PRIO_EN
  assign search_base = 0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_inc;

  assign owner_inc   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign search_base = 32'(ptr_q);

  // The pointer moves past the owner whenever ownership ends, whether by
  // completion (DONE) or by the owner dropping its request (abort).
  always_comb begin
    ptr_d = ptr_q;
    if (Enable_In && (state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      ptr_d = owner_inc;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Circular search: first set request at or after search_base.
  always_comb begin
    int unsigned cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = search_base + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_valid && Req_In[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    steps_d = steps_q;
    j_load  = 1'b0;
    j_step  = 1'b0;
    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_d = pick_idx;
            steps_d = req_len[pick_idx];
            j_load  = 1'b1;
            state_d = (req_len[pick_idx] == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // Dropping the request aborts the run; the timer keeps its value.
          if (!Req_In[owner_q]) begin
            state_d = ST_IDLE;
          end else begin
            j_step  = 1'b1;
            steps_d = steps_q - 1'b1;
            if (steps_q == LEN_WIDTH'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      steps_q <= steps_d;
    end
  end

  johnson_step_reg #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_step_reg (
    .clk    (Clk_In),
    .rst_n  (Reset_In),
    .load_i (j_load),
    .step_i (j_step),
    .j_o    (Johnson_State_Out)
  );

  assign Busy_Out       = (state_q != ST_IDLE);
  assign Steps_Left_Out = steps_q;

  // Done is gated by Enable_In so a frozen DONE state pulses only once
  // operation resumes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out
    assign Grant_Out[gi] = Busy_Out && (owner_q == IDX_W'(gi));
    assign Done_Out[gi]  = (state_q == ST_DONE) && Enable_In && (owner_q == IDX_W'(gi));
  end

endmodule

// File: tb/tb_johnson_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_johnson_timer_arbiter
//   Directed bench for johnson_timer_arbiter (NUM_REQ=4, CNT_WIDTH=8,
//   LEN_WIDTH=8). A table of per-cycle vectors covers a single run, a
//   zero-length run and an abort; hand-written sequences cover wrap, enable
//   freeze, pending DONE under freeze, reset mid-run and arbitration order.
// -----------------------------------------------------------------------------
module tb_johnson_timer_arbiter;

  logic        Clk_In;
  logic        Reset_In;
  logic        Enable_In;
  logic [3:0]  Req_In;
  logic [31:0] Req_Len_In;
  logic [3:0]  Grant_Out;
  logic        Busy_Out;
  logic [3:0]  Done_Out;
  logic [7:0]  Johnson_State_Out;
  logic [7:0]  Steps_Left_Out;

  int n_cmp = 0;
  int n_bad = 0;

  johnson_timer_arbiter #(
    .NUM_REQ   (4),
    .CNT_WIDTH (8),
    .LEN_WIDTH (8)
  ) dut (
    .Clk_In            (Clk_In),
    .Reset_In          (Reset_In),
    .Enable_In         (Enable_In),
    .Req_In            (Req_In),
    .Req_Len_In        (Req_Len_In),
    .Grant_Out         (Grant_Out),
    .Busy_Out          (Busy_Out),
    .Done_Out          (Done_Out),
    .Johnson_State_Out (Johnson_State_Out),
    .Steps_Left_Out    (Steps_Left_Out)
  );

  initial Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;
    logic [7:0]  j;
    logic [7:0]  steps;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic en, input logic [3:0] req, input logic [31:0] len,
                              input logic [3:0] grant, input logic busy, input logic [3:0] done,
                              input logic [7:0] j, input logic [7:0] steps);
    vec_t v;
    v.en = en; v.req = req; v.len = len; v.grant = grant;
    v.busy = busy; v.done = done; v.j = j; v.steps = steps;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] grant, input logic busy,
                         input logic [3:0] done, input logic [7:0] j, input logic [7:0] steps);
    chk({tag, " grant"}, 32'(Grant_Out), 32'(grant));
    chk({tag, " busy"},  32'(Busy_Out), 32'(busy));
    chk({tag, " done"},  32'(Done_Out), 32'(done));
    chk({tag, " J"},     32'(Johnson_State_Out), 32'(j));
    chk({tag, " steps"}, 32'(Steps_Left_Out), 32'(steps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int obs;
    logic [3:0] exp_g;

    // Single run, zero-length run, abort with a mid-run length change.
    vecs[0]  = mk(1, 4'b0001, 32'h0000_0003, 4'b0001, 1, 4'b0000, 8'h01, 8'd3);
    vecs[1]  = mk(1, 4'b0001, 32'h0000_0003, 4'b0001, 1, 4'b0000, 8'h03, 8'd2);
    vecs[2]  = mk(1, 4'b0001, 32'h0000_0003, 4'b0001, 1, 4'b0000, 8'h07, 8'd1);
    vecs[3]  = mk(1, 4'b0001, 32'h0000_0003, 4'b0001, 1, 4'b0001, 8'h0F, 8'd0);
    vecs[4]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 8'h0F, 8'd0);
    vecs[5]  = mk(1, 4'b0100, 32'h0000_0000, 4'b0100, 1, 4'b0100, 8'h01, 8'd0);
    vecs[6]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 8'h01, 8'd0);
    vecs[7]  = mk(1, 4'b0010, 32'h0000_0A00, 4'b0010, 1, 4'b0000, 8'h01, 8'd10);
    vecs[8]  = mk(1, 4'b0010, 32'h0000_0A00, 4'b0010, 1, 4'b0000, 8'h03, 8'd9);
    vecs[9]  = mk(1, 4'b0010, 32'h0000_FF00, 4'b0010, 1, 4'b0000, 8'h07, 8'd8);
    vecs[10] = mk(1, 4'b0010, 32'h0000_0000, 4'b0010, 1, 4'b0000, 8'h0F, 8'd7);
    vecs[11] = mk(1, 4'b0010, 32'h0000_FF00, 4'b0010, 1, 4'b0000, 8'h1F, 8'd6);
    vecs[12] = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 8'h1F, 8'd6);
    vecs[13] = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 8'h1F, 8'd6);

    Reset_In   = 1'b0;
    Enable_In  = 1'b1;
    Req_In     = '0;
    Req_Len_In = '0;
    repeat (2) @(posedge Clk_In);
    #1;
    chk_all("reset", 4'b0000, 0, 4'b0000, 8'h01, 8'd0);
    Reset_In = 1'b1;

    for (int i = 0; i < 14; i++) begin
      Enable_In  = vecs[i].en;
      Req_In     = vecs[i].req;
      Req_Len_In = vecs[i].len;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].done,
              vecs[i].j, vecs[i].steps);
      $display("vec%0d req=%b grant=%b done=%b J=%h steps=%0d", i, Req_In, Grant_Out,
               Done_Out, Johnson_State_Out, Steps_Left_Out);
    end

    // Wrap: 17 steps from 0x01 land on 0x03; DONE is the 18th observed cycle.
    Req_In = 4'b1000; Req_Len_In = 32'h1100_0000;
    tick(); obs = 1;
    chk("wrap load grant", 32'(Grant_Out), 32'h8);
    chk("wrap load steps", 32'(Steps_Left_Out), 32'd17);
    while (Done_Out == 4'b0000 && obs < 40) begin
      tick(); obs++;
    end
    chk("wrap done latency", 32'(obs), 32'd18);
    chk("wrap done", 32'(Done_Out), 32'h8);
    chk("wrap J", 32'(Johnson_State_Out), 32'h03);
    $display("wrap obs=%0d J=%h done=%b", obs, Johnson_State_Out, Done_Out);
    Req_In = '0; Req_Len_In = '0;
    tick();
    chk("wrap idle busy", 32'(Busy_Out), 32'd0);

    // Freeze for 5 cycles mid-run with length 6: Done slips by 5 cycles.
    Req_In = 4'b0001; Req_Len_In = 32'h0000_0006;
    tick(); obs = 1;
    chk("freeze load grant", 32'(Grant_Out), 32'h1);
    tick(); tick(); obs = 3;
    Enable_In = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); obs++;
      chk($sformatf("freeze c%0d done", c), 32'(Done_Out), 32'd0);
    end
    chk("freeze J hold", 32'(Johnson_State_Out), 32'h07);
    chk("freeze steps hold", 32'(Steps_Left_Out), 32'd4);
    chk("freeze grant hold", 32'(Grant_Out), 32'h1);
    Enable_In = 1'b1;
    while (Done_Out == 4'b0000 && obs < 40) begin
      tick(); obs++;
    end
    chk("freeze done latency", 32'(obs), 32'd12);
    chk("freeze done", 32'(Done_Out), 32'h1);
    chk("freeze J", 32'(Johnson_State_Out), 32'h7F);
    $display("freeze obs=%0d J=%h done=%b", obs, Johnson_State_Out, Done_Out);
    Req_In = '0; Req_Len_In = '0;
    tick();

    // Zero-length run whose DONE is frozen: pulse suppressed, then delivered.
    Req_In = 4'b0010; Req_Len_In = '0;
    tick();
    chk("pend first done", 32'(Done_Out), 32'h2);
    Enable_In = 1'b0;
    #1;
    chk("pend gated done", 32'(Done_Out), 32'd0);
    Req_In = '0;
    tick();
    chk("pend held done", 32'(Done_Out), 32'd0);
    chk("pend held grant", 32'(Grant_Out), 32'h2);
    Enable_In = 1'b1;
    #1;
    chk("pend resumed done", 32'(Done_Out), 32'h2);
    tick();
    chk("pend idle busy", 32'(Busy_Out), 32'd0);
    $display("pending-done sequence grant=%b busy=%b", Grant_Out, Busy_Out);

    // Reset mid-run: everything clears immediately, no Done.
    Req_In = 4'b0010; Req_Len_In = 32'h0000_0A00;
    tick(); tick(); tick();
    chk("rstrun grant before", 32'(Grant_Out), 32'h2);
    #2;
    Reset_In = 1'b0;
    #1;
    chk_all("rstrun", 4'b0000, 0, 4'b0000, 8'h01, 8'd0);
    tick();
    chk("rstrun held done", 32'(Done_Out), 32'd0);
    Req_In = '0; Req_Len_In = '0;
    Reset_In = 1'b1;
    tick();

    // Arbitration order with all four requesting, all lengths 1.
    Req_In = 4'b1111; Req_Len_In = 32'h0101_0101;
    for (int g = 0; g < 5; g++) begin
`ifdef JOHNSON_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (g % 4);
`endif
      tick();
      chk_all($sformatf("rr%0d run", g), exp_g, 1, 4'b0000, 8'h01, 8'd1);
      tick();
      chk_all($sformatf("rr%0d done", g), exp_g, 1, exp_g, 8'h03, 8'd0);
      tick();
      chk($sformatf("rr%0d gap", g), 32'(Grant_Out), 32'd0);
      $display("rr grant%0d expected=%b", g, exp_g);
    end
    Req_In = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
